// File: rtl/mem_arbiter_if.sv
// Client and memory-side signals of the two-port scratch-memory arbiter.
// master = clients plus the memory model, slave = the arbiter itself.
interface mem_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
);
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              ack0;
  logic [DATA_W-1:0] rdata0;
  logic              gnt0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              ack1;
  logic [DATA_W-1:0] rdata1;
  logic              gnt1;

  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_add;
  logic [DATA_W-1:0] mem_wData;
  logic [DATA_W-1:0] mem_rData;

  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rData,
    input  ack0, rdata0, gnt0, ack1, rdata1, gnt1,
    input  mem_we, mem_re, mem_add, mem_wData
  );

  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rData,
    output ack0, rdata0, gnt0, ack1, rdata1, gnt1,
    output mem_we, mem_re, mem_add, mem_wData
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter serialising client accesses onto a
// single-port 8x32 scratch memory; one transaction every four cycles.
module mem_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_ACK   = 2'd3;

  logic [1:0]        r_state;
  logic              r_last;
  logic              r_win;
  logic              r_rd;
  logic              r_ack0;
  logic              r_ack1;
  logic              r_gnt0;
  logic              r_gnt1;
  logic              r_mem_we;
  logic              r_mem_re;
  logic [ADDR_W-1:0] r_mem_add;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;

  logic              w_any;
  logic              w_pick;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  // Tie goes to the port that was not granted last.
  assign w_any   = bus.req0 | bus.req1;
  assign w_pick  = (bus.req0 && bus.req1) ? ~r_last : bus.req1;
  assign w_we    = w_pick ? bus.we1    : bus.we0;
  assign w_addr  = w_pick ? bus.addr1  : bus.addr0;
  assign w_wdata = w_pick ? bus.wdata1 : bus.wdata0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_last      <= 1'b1;
      r_win       <= 1'b0;
      r_rd        <= 1'b0;
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
      r_mem_add   <= '0;
      r_mem_wdata <= '0;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
    end else begin
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_mem_we <= 1'b0;
      r_mem_re <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_win       <= w_pick;
            r_last      <= w_pick;
            r_rd        <= ~w_we;
            r_gnt0      <= ~w_pick;
            r_gnt1      <= w_pick;
            // Strobes are launched with the grant so they are high during ISSUE.
            r_mem_we    <= w_we;
            r_mem_re    <= ~w_we;
            r_mem_add   <= w_addr;
            r_mem_wdata <= w_wdata;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT: begin
          if (r_rd) begin
            if (r_win) r_rdata1 <= bus.mem_rData;
            else       r_rdata0 <= bus.mem_rData;
          end
          r_ack0  <= ~r_win;
          r_ack1  <= r_win;
          r_state <= S_ACK;
        end
        S_ACK: begin
          r_gnt0  <= 1'b0;
          r_gnt1  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ack0      = r_ack0;
  assign bus.ack1      = r_ack1;
  assign bus.gnt0      = r_gnt0;
  assign bus.gnt1      = r_gnt1;
  assign bus.rdata0    = r_rdata0;
  assign bus.rdata1    = r_rdata1;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_re    = r_mem_re;
  assign bus.mem_add   = r_mem_add;
  assign bus.mem_wData = r_mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: scratch memory model, timeline-based reference
// model checked every cycle, plus directed scenarios with literal expectations.
module tb_mem_arbiter;
  localparam int DW = 32;
  localparam int AW = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  mem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  mem_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit hold0    = 1'b0;
  bit hold1    = 1'b0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scratch memory: write on mem_we, registered read data one cycle after mem_re.
  logic [DW-1:0] tb_mem [8] = '{32'h00000000, 32'h11111111, 32'h22222222, 32'h33333333,
                                32'h44444444, 32'h55555555, 32'h66666666, 32'h77777777};
  always @(posedge clk) begin
    if (bus.mem_we) tb_mem[bus.mem_add] <= bus.mem_wData;
    if (bus.mem_re) bus.mem_rData <= tb_mem[bus.mem_add];
  end

  // Reference model: a granted transaction at edge g shows strobe after g,
  // gnt after g..g+2, ack after g+2; the next grant may happen at edge g+4.
  int            ecnt      = 0;
  int            m_g       = 0;
  bit            m_started = 1'b0;
  bit            m_active  = 1'b0;
  bit            m_last    = 1'b1;
  bit            m_win     = 1'b0;
  bit            m_we      = 1'b0;
  logic [AW-1:0] m_addr    = '0;
  logic [DW-1:0] m_wdata   = '0;
  logic [DW-1:0] m_rdata0  = '0;
  logic [DW-1:0] m_rdata1  = '0;
  logic [DW-1:0] m_mem [8] = '{32'h00000000, 32'h11111111, 32'h22222222, 32'h33333333,
                               32'h44444444, 32'h55555555, 32'h66666666, 32'h77777777};
  int   m_d;
  logic m_pick;
  assign m_d    = ecnt - m_g;
  assign m_pick = (bus.req0 && bus.req1) ? !m_last : bus.req1;

  always @(posedge clk) begin
    ecnt <= ecnt + 1;
    if (reset) begin
      m_started <= 1'b1;
      m_active  <= 1'b0;
      m_last    <= 1'b1;
      m_addr    <= '0;
      m_wdata   <= '0;
      m_rdata0  <= '0;
      m_rdata1  <= '0;
    end else if (!m_active || m_d >= 4) begin
      if (bus.req0 || bus.req1) begin
        m_active <= 1'b1;
        m_g      <= ecnt;
        m_win    <= m_pick;
        m_last   <= m_pick;
        m_we     <= m_pick ? bus.we1    : bus.we0;
        m_addr   <= m_pick ? bus.addr1  : bus.addr0;
        m_wdata  <= m_pick ? bus.wdata1 : bus.wdata0;
      end else begin
        m_active <= 1'b0;
      end
    end else if (m_d == 1 && m_we) begin
      m_mem[m_addr] <= m_wdata;
    end else if (m_d == 2 && !m_we) begin
      if (m_win) m_rdata1 <= m_mem[m_addr];
      else       m_rdata0 <= m_mem[m_addr];
    end
  end

  int   e_d;
  logic e_on, e_str, e_ack;
  assign e_d   = ecnt - 1 - m_g;
  assign e_on  = m_active && (e_d <= 2);
  assign e_str = m_active && (e_d == 0);
  assign e_ack = m_active && (e_d == 2);

  always @(negedge clk) begin
    if (m_started) begin
      chk1("gnt0", bus.gnt0, e_on && !m_win);
      chk1("gnt1", bus.gnt1, e_on && m_win);
      chk1("ack0", bus.ack0, e_ack && !m_win);
      chk1("ack1", bus.ack1, e_ack && m_win);
      chk1("mem_we", bus.mem_we, e_str && m_we);
      chk1("mem_re", bus.mem_re, e_str && !m_we);
      chk32("mem_add", 32'(bus.mem_add), 32'(m_addr));
      chk32("mem_wData", bus.mem_wData, m_wdata);
      chk32("rdata0", bus.rdata0, m_rdata0);
      chk32("rdata1", bus.rdata1, m_rdata1);
      chk1("ack_excl", bus.ack0 && bus.ack1, 1'b0);
      chk1("gnt_excl", bus.gnt0 && bus.gnt1, 1'b0);
      chk1("strobe_excl", bus.mem_we && bus.mem_re, 1'b0);
    end
  end

  // Clients drop req on the cycle their ack is seen, unless told to hold it.
  task automatic step();
    @(negedge clk);
    if (bus.ack0 === 1'b1 && !hold0) bus.req0 = 1'b0;
    if (bus.ack1 === 1'b1 && !hold1) bus.req1 = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic issue(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p == 0) begin
      bus.we0 = we; bus.addr0 = a; bus.wdata0 = d; bus.req0 = 1'b1;
    end else begin
      bus.we1 = we; bus.addr1 = a; bus.wdata1 = d; bus.req1 = 1'b1;
    end
  endtask

  task automatic wait_ack(input int p, input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      step();
      seen = (p == 0) ? (bus.ack0 === 1'b1) : (bus.ack1 === 1'b1);
    end
    chk1({name, "_ack_seen"}, seen, 1'b1);
  endtask

  task automatic txn(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input string name);
    issue(p, we, a, d);
    wait_ack(p, name);
    step();
  endtask

  int   ack_port[$];
  int   ack_cyc[$];
  int   exp_port [4] = '{0, 1, 0, 1};
  int   exp_cyc  [4] = '{3, 7, 11, 15};

  initial begin
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
    reset = 1'b1;
    steps(2);
    chk1("rst_gnt0", bus.gnt0, 1'b0);
    chk1("rst_ack1", bus.ack1, 1'b0);
    chk32("rst_mem_add", 32'(bus.mem_add), 32'd0);
    chk32("rst_rdata0", bus.rdata0, 32'd0);
    reset = 1'b0;

    // Single write from port 0
    issue(0, 1'b1, 3'd5, 32'hDEADBEEF);
    step();
    chk1("t1_we", bus.mem_we, 1'b1);
    chk1("t1_re", bus.mem_re, 1'b0);
    chk32("t1_add", 32'(bus.mem_add), 32'd5);
    chk32("t1_wdata", bus.mem_wData, 32'hDEADBEEF);
    chk1("t1_gnt0", bus.gnt0, 1'b1);
    step();
    chk1("t1_we_off", bus.mem_we, 1'b0);
    chk1("t1_ack_early", bus.ack0, 1'b0);
    step();
    chk1("t1_ack0", bus.ack0, 1'b1);
    step();
    chk1("t1_ack_once", bus.ack0, 1'b0);

    // Port 1 reads back the same word
    issue(1, 1'b0, 3'd5, 32'd0);
    step();
    chk1("t2_re", bus.mem_re, 1'b1);
    steps(2);
    chk1("t2_ack1", bus.ack1, 1'b1);
    chk32("t2_rdata1", bus.rdata1, 32'hDEADBEEF);
    chk32("t2_rdata0", bus.rdata0, 32'd0);
    step();

    // Tie right after reset: port 0 first
    reset = 1'b1;
    step();
    reset = 1'b0;
    issue(0, 1'b1, 3'd1, 32'hA1A1A1A1);
    issue(1, 1'b1, 3'd2, 32'hB2B2B2B2);
    steps(3);
    chk1("t3_ack0", bus.ack0, 1'b1);
    chk1("t3_ack1_not", bus.ack1, 1'b0);
    steps(2);
    chk1("t3_gnt1", bus.gnt1, 1'b1);
    chk1("t3_strobe1", bus.mem_we, 1'b1);
    chk32("t3_add", 32'(bus.mem_add), 32'd2);
    steps(2);
    chk1("t3_ack1", bus.ack1, 1'b1);
    step();

    // Both held high for 16 cycles: strict alternation
    hold0 = 1'b1; hold1 = 1'b1;
    issue(0, 1'b0, 3'd1, 32'd0);
    issue(1, 1'b0, 3'd2, 32'd0);
    for (int i = 1; i <= 16; i++) begin
      step();
      if (bus.ack0 === 1'b1) begin ack_port.push_back(0); ack_cyc.push_back(i); end
      if (bus.ack1 === 1'b1) begin ack_port.push_back(1); ack_cyc.push_back(i); end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    hold0 = 1'b0; hold1 = 1'b0;
    chk32("t4_nacks", 32'(ack_port.size()), 32'd4);
    for (int k = 0; k < 4 && k < ack_port.size(); k++) begin
      chk32("t4_ack_port", 32'(ack_port[k]), 32'(exp_port[k]));
      chk32("t4_ack_cyc", 32'(ack_cyc[k]), 32'(exp_cyc[k]));
    end
    chk32("t4_rdata0", bus.rdata0, 32'hA1A1A1A1);
    chk32("t4_rdata1", bus.rdata1, 32'hB2B2B2B2);
    step();

    // Reset during WAIT of a port 0 read, then restart
    issue(0, 1'b0, 3'd2, 32'd0);
    steps(2);
    reset = 1'b1;
    step();
    chk1("t5_gnt0", bus.gnt0, 1'b0);
    chk1("t5_ack0", bus.ack0, 1'b0);
    chk1("t5_re", bus.mem_re, 1'b0);
    chk32("t5_add", 32'(bus.mem_add), 32'd0);
    chk32("t5_rdata0", bus.rdata0, 32'd0);
    chk32("t5_rdata1", bus.rdata1, 32'd0);
    reset = 1'b0;
    steps(3);
    chk1("t5_ack0_restart", bus.ack0, 1'b1);
    chk32("t5_rdata0_restart", bus.rdata0, 32'hB2B2B2B2);
    step();

    // Fields changing after the grant are ignored
    issue(0, 1'b1, 3'd3, 32'h33C0FFEE);
    step();
    bus.addr0  = 3'd6;
    bus.wdata0 = 32'h0BADBAD0;
    chk32("t6_add", 32'(bus.mem_add), 32'd3);
    step();
    chk32("t6_add_hold", 32'(bus.mem_add), 32'd3);
    chk32("t6_wdata_hold", bus.mem_wData, 32'h33C0FFEE);
    step();
    chk1("t6_ack0", bus.ack0, 1'b1);
    step();
    txn(1, 1'b0, 3'd3, 32'd0, "t6_rd3");
    chk32("t6_rdata3", bus.rdata1, 32'h33C0FFEE);
    txn(1, 1'b0, 3'd6, 32'd0, "t6_rd6");
    chk32("t6_rdata6", bus.rdata1, 32'h66666666);

    // Top address
    txn(0, 1'b1, 3'd7, 32'h77AA77AA, "t7_wr");
    txn(1, 1'b0, 3'd7, 32'd0, "t7_rd");
    chk32("t7_rdata1", bus.rdata1, 32'h77AA77AA);
    chk32("t7_rdata0_kept", bus.rdata0, 32'hB2B2B2B2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the 8-word x 32-bit single-port scratch memory (we/re strobes, 3-bit address, registered read data).
- Sits between two datapath clients and the memory, serialising their accesses into one memory operation at a time.
- Returns read data and a per-port completion acknowledge.

Parameters:
- DATA_W, 32, data width of memory words and client data.
- ADDR_W, 3, memory address width (8 words).

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- req0  input  1  port 0 request; held high until ack0.
- we0  input  1  port 0 operation: 1 = write, 0 = read.
- addr0  input  ADDR_W  port 0 address.
- wdata0  input  DATA_W  port 0 write data.
- ack0  output  1  port 0 completion pulse (1 cycle).
- rdata0  output  DATA_W  port 0 read data, valid with ack0 on reads, held until next port 0 read completes.
- gnt0  output  1  port 0 owns the memory (ISSUE..ACK).
- req1, we1, addr1, wdata1, ack1, rdata1, gnt1: same as port 0 for port 1.
- mem_we  output  1  memory write strobe.
- mem_re  output  1  memory read strobe.
- mem_add  output  ADDR_W  memory address.
- mem_wData  output  DATA_W  memory write data.
- mem_rData  input  DATA_W  memory read data (valid the cycle after mem_re).

Behaviour:
- Reset (clk edge with reset=1): state IDLE; all outputs 0 (acks, gnts, strobes, mem_add, mem_wData, rdata0/1); rr pointer = "last granted port 1", so port 0 wins the first tie. Reset overrides every state, including mid-transaction; the in-flight transaction is dropped with no ack.
- FSM: IDLE -> ISSUE -> WAIT -> ACK -> IDLE. All outputs registered.
- IDLE: sample req0/req1. None: stay. One: grant it. Both: grant the port not granted last. On grant, latch winner's we/addr/wdata into internal registers, update rr pointer, raise gnt of winner, go ISSUE.
- ISSUE (1 cycle): mem_we = latched we, mem_re = ~latched we, mem_add/mem_wData = latched values. Exactly one strobe high for exactly one cycle. -> WAIT.
- WAIT (1 cycle): strobes low; mem_add/mem_wData hold. For reads, mem_rData is valid this cycle and is captured into the winner's rdata at the end of it. -> ACK.
- ACK (1 cycle): winner's ack = 1, its rdata updated (reads only; writes leave rdata unchanged). gnt drops at ACK exit. -> IDLE.
- Latency: req seen in IDLE at cycle T -> strobe at T+1 -> ack at T+3. Max throughput: 1 transaction per 4 cycles.
- Client fields are sampled only in IDLE; later changes do not affect the active transaction.
- A req still high in the IDLE cycle after its ack is a new request. Clients drop req on the cycle ack is seen.
- Loser's req stays pending; no ack, no rdata change, served at the next IDLE in which it wins.
- Never both acks, both gnts, or both strobes high at once.
- Addresses use the full ADDR_W range, with no wrap logic; address 7 is legal.

Test Plan:
- After reset, req0=1, we0=1, addr0=5, wdata0=0xDEADBEEF in cycle T -> mem_we=1, mem_add=5, mem_wData=0xDEADBEEF only at T+1; mem_re never high; ack0=1 only at T+3; gnt0 high T+1..T+3.
- Then req1=1, we1=0, addr1=5 -> mem_re=1 at strobe cycle; ack1 pulse 2 cycles later with rdata1=0xDEADBEEF; rdata0 unchanged.
- Immediately after reset, req0 and req1 both high together (writes to 1 and 2) -> port 0 served first (ack0 at T+3), port 1 next (strobe T+5, ack1 T+7).
- Both reqs held high continuously for 16 cycles -> grants alternate 0,1,0,1; acks spaced 4 cycles apart; acks never coincide.
- Port 0 read starts, reset pulsed during WAIT -> next cycle all outputs 0, no ack0, state IDLE; with req0 still high, the transaction restarts and acks normally 3 cycles after the IDLE sample.
- Port 0 changes addr0 from 3 to 6 one cycle after grant -> memory access uses address 3.
